// File: rtl/exe_stage_mdu.sv
// exe_stage_mdu: MIPS execute stage with operand forwarding, ALU, branch/JR resolution,
// an iterative multiply/divide unit with HI/LO, and the EX/MEM register. Divider built only with EXE_MDU_DIV_EN.
module exe_stage_mdu #(
  parameter int unsigned W  = 32,
  parameter int unsigned RA = 5,
  parameter int unsigned CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_in,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [3:0]    id_op,
  input  logic          id_use_imm,
  input  logic [W-1:0]  id_imm,
  input  logic [W-1:0]  id_pc,
  input  logic [W-1:0]  id_rega,
  input  logic [W-1:0]  id_regb,
  input  logic [RA-1:0] id_rs,
  input  logic [RA-1:0] id_rt,
  input  logic [RA-1:0] id_rd,
  input  logic          id_regwr,
  input  logic [1:0]    id_br,
  input  logic [CW-1:0] id_ctl,
  input  logic [RA-1:0] mem_rd,
  input  logic [RA-1:0] wb_rd,
  input  logic          mem_regwr,
  input  logic          wb_regwr,
  input  logic [W-1:0]  mem_data,
  input  logic [W-1:0]  wb_data,
  output logic          ex_valid,
  output logic          ex_regwr,
  output logic [RA-1:0] ex_rd,
  output logic [CW-1:0] ex_ctl,
  output logic [W-1:0]  ex_result,
  output logic [W-1:0]  ex_storedata,
  output logic [W-1:0]  ex_pc,
  output logic          pc_sel,
  output logic [W-1:0]  pc_target,
  output logic          stall_out,
  output logic          mdu_busy
);

  localparam int unsigned SHW  = $clog2(W);
  localparam int unsigned CNTW = $clog2(W) + 1;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO
  } aluOp_t;

  typedef enum logic [1:0] {BR_NONE, BR_BEQ, BR_BNE, BR_JR} brKind_t;

  typedef enum logic {MDU_IDLE, MDU_RUN} mduState_t;

  aluOp_t    op;
  brKind_t   br;
  mduState_t state, stateNext;

  logic [W-1:0]    fwdA, fwdB, opB, aluRes;
  logic [W-1:0]    hiReg, loReg;
  logic [W-1:0]    accReg, mqReg, opbReg;
  logic [CNTW-1:0] cnt;
  logic            negRes;
  logic            live, brTaken, isMduOp, isMfx, mduAccept, mduStart, sgn;
  logic [W-1:0]    magA, magB;
  logic [W:0]      mulSum;
  logic [W-1:0]    nextAcc, nextMq, finHi, finLo;
  logic [2*W-1:0]  prodRaw, prodFix;

`ifdef EXE_MDU_DIV_EN
  logic         isDiv, negRem, divZero;
  logic [W:0]   divShift;
  logic [W-1:0] divSub;
  logic         divGe;
`endif

  assign op = aluOp_t'(id_op);
  assign br = brKind_t'(id_br);

  // Forwarding: MEM stage beats WB stage; register 0 is never forwarded.
  always_comb begin
    fwdA = id_rega;
    if (id_rs != '0) begin
      if (mem_regwr && (mem_rd == id_rs))     fwdA = mem_data;
      else if (wb_regwr && (wb_rd == id_rs))  fwdA = wb_data;
    end
  end

  always_comb begin
    fwdB = id_regb;
    if (id_rt != '0) begin
      if (mem_regwr && (mem_rd == id_rt))     fwdB = mem_data;
      else if (wb_regwr && (wb_rd == id_rt))  fwdB = wb_data;
    end
  end

  assign opB = id_use_imm ? id_imm : fwdB;

  always_comb begin
    aluRes = '0;
    case (op)
      OP_ADD:  aluRes = fwdA + opB;
      OP_SUB:  aluRes = fwdA - opB;
      OP_AND:  aluRes = fwdA & opB;
      OP_OR:   aluRes = fwdA | opB;
      OP_XOR:  aluRes = fwdA ^ opB;
      OP_NOR:  aluRes = ~(fwdA | opB);
      OP_SLT:  aluRes = W'($signed(fwdA) < $signed(opB));
      OP_SLTU: aluRes = W'(fwdA < opB);
      OP_SLL:  aluRes = opB << fwdA[SHW-1:0];
      OP_SRL:  aluRes = opB >> fwdA[SHW-1:0];
      OP_MFHI: aluRes = hiReg;
      OP_MFLO: aluRes = loReg;
      default: aluRes = '0;
    endcase
  end

  assign isMduOp = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign isMfx   = (op == OP_MFHI) || (op == OP_MFLO);

`ifdef EXE_MDU_DIV_EN
  assign mduAccept = isMduOp;
  assign sgn       = (op == OP_MULT) || (op == OP_DIV);
`else
  assign mduAccept = (op == OP_MULT) || (op == OP_MULTU);
  assign sgn       = (op == OP_MULT);
`endif

  assign live     = id_valid & ~flush & ~stall_out;
  assign mduStart = live & ~stall_in & (state == MDU_IDLE) & mduAccept;

  always_comb begin
    brTaken = ((br == BR_BEQ) && (fwdA == fwdB)) ||
              ((br == BR_BNE) && (fwdA != fwdB)) ||
              (br == BR_JR);
    pc_sel    = live & brTaken;
    pc_target = (br == BR_JR) ? fwdA : id_pc + (id_imm << 2);
  end

  // MDU FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= stateNext;
  end

  // MDU FSM: next state
  always_comb begin
    stateNext = state;
    case (state)
      MDU_IDLE: if (mduStart) stateNext = MDU_RUN;
      MDU_RUN:  if (!stall_in && (cnt == CNTW'(1))) stateNext = MDU_IDLE;
      default:  stateNext = MDU_IDLE;
    endcase
  end

  // MDU FSM: outputs
  always_comb begin
    mdu_busy  = (state == MDU_RUN);
    stall_out = mdu_busy | (id_valid & isMfx & (state == MDU_RUN));
  end

  assign magA = (sgn && fwdA[W-1]) ? ('0 - fwdA) : fwdA;
  assign magB = (sgn && fwdB[W-1]) ? ('0 - fwdB) : fwdB;

  // Shift-add multiply: {accReg, mqReg} shifts right, multiplier bits leave via mqReg[0].
  assign mulSum = {1'b0, accReg} + (mqReg[0] ? {1'b0, opbReg} : '0);

`ifdef EXE_MDU_DIV_EN
  // Restoring divide: partial remainder in accReg, quotient bits enter mqReg from the right.
  assign divShift = {accReg, mqReg[W-1]};
  assign divGe    = (divShift >= {1'b0, opbReg});
  assign divSub   = divShift[W-1:0] - opbReg;

  always_comb begin
    if (isDiv) begin
      nextAcc = divGe ? divSub : divShift[W-1:0];
      nextMq  = {mqReg[W-2:0], divGe};
    end else begin
      nextAcc = mulSum[W:1];
      nextMq  = {mulSum[0], mqReg[W-1:1]};
    end
  end
`else
  assign nextAcc = mulSum[W:1];
  assign nextMq  = {mulSum[0], mqReg[W-1:1]};
`endif

  assign prodRaw = {nextAcc, nextMq};
  assign prodFix = negRes ? ('0 - prodRaw) : prodRaw;

`ifdef EXE_MDU_DIV_EN
  // Zero divisor leaves the dividend magnitude in accReg, so only LO needs overriding.
  always_comb begin
    if (isDiv) begin
      finLo = divZero ? '1 : (negRes ? ('0 - nextMq) : nextMq);
      finHi = negRem ? ('0 - nextAcc) : nextAcc;
    end else begin
      {finHi, finLo} = prodFix;
    end
  end
`else
  assign {finHi, finLo} = prodFix;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accReg <= '0;
      mqReg  <= '0;
      opbReg <= '0;
      cnt    <= '0;
      negRes <= 1'b0;
      hiReg  <= '0;
      loReg  <= '0;
`ifdef EXE_MDU_DIV_EN
      isDiv   <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
`endif
    end else if (mduStart) begin
      accReg <= '0;
      mqReg  <= magA;
      opbReg <= magB;
      cnt    <= CNTW'(W);
      negRes <= sgn & (fwdA[W-1] ^ fwdB[W-1]);
`ifdef EXE_MDU_DIV_EN
      isDiv   <= (op == OP_DIV) || (op == OP_DIVU);
      negRem  <= sgn & fwdA[W-1];
      divZero <= (fwdB == '0);
`endif
    end else if ((state == MDU_RUN) && !stall_in) begin
      accReg <= nextAcc;
      mqReg  <= nextMq;
      cnt    <= cnt - CNTW'(1);
      if (cnt == CNTW'(1)) begin
        hiReg <= finHi;
        loReg <= finLo;
      end
    end
  end

  // EX/MEM pipeline register; MDU ops retire here without a register write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_regwr     <= 1'b0;
      ex_rd        <= '0;
      ex_ctl       <= '0;
      ex_result    <= '0;
      ex_storedata <= '0;
      ex_pc        <= '0;
    end else if (!stall_in) begin
      if (live) begin
        ex_valid     <= 1'b1;
        ex_regwr     <= id_regwr & ~isMduOp;
        ex_rd        <= id_rd;
        ex_ctl       <= id_ctl;
        ex_result    <= aluRes;
        ex_storedata <= fwdB;
        ex_pc        <= id_pc;
      end else begin
        ex_valid     <= 1'b0;
        ex_regwr     <= 1'b0;
        ex_rd        <= '0;
        ex_ctl       <= '0;
        ex_result    <= '0;
        ex_storedata <= '0;
        ex_pc        <= '0;
      end
    end
  end

endmodule

// File: doc/exe_stage_mdu.md
# exe_stage_mdu

Parametrised execute stage for the pipelined MIPS core: operand forwarding, single-cycle ALU, branch/jump-register resolution, and an iterative multiply/divide unit (MDU) with HI/LO registers and a stall handshake back to ID. It sits between the ID/EX and EX/MEM boundaries and owns the EX/MEM pipeline register. Width, register-address width and pass-through control width are generic.

## Interface
- W, 32, datapath width (≥8, power of two)
- RA, 5, register address width
- CW, 7, MEM/WB control bits carried unchanged to EX/MEM
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall_in  in  1  downstream/debug freeze; holds EX/MEM register and MDU
- flush  in  1  turns current ID/EX input into a bubble
- id_valid  in  1  ID/EX holds a real instruction
- id_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLTU,8 SLL,9 SRL,10 MULT,11 MULTU,12 DIV,13 DIVU,14 MFHI,15 MFLO
- id_use_imm  in  1  B operand = id_imm
- id_imm, id_pc, id_rega, id_regb  in  W  immediate (pre-extended), PC+4, register file reads
- id_rs, id_rt, id_rd  in  RA  source/destination addresses
- id_regwr  in  1  instruction writes id_rd
- id_br  in  2  00 none, 01 BEQ, 10 BNE, 11 JR
- id_ctl  in  CW  pass-through controls
- mem_rd, wb_rd  in  RA; mem_regwr, wb_regwr  in  1; mem_data, wb_data  in  W  forwarding sources
- ex_valid, ex_regwr  out  1; ex_rd  out  RA; ex_ctl  out  CW; ex_result, ex_storedata, ex_pc  out  W  EX/MEM register
- pc_sel  out  1; pc_target  out  W  combinational redirect
- stall_out  out  1  ID must hold its instruction
- mdu_busy  out  1  MDU iterating

## Operation
- Forwarding per operand: address 0 never forwarded; MEM match (mem_regwr, mem_rd==addr) beats WB match; else register file value. ex_storedata = forwarded B (before immediate mux).
- ALU: SLT signed, SLTU unsigned; SLL/SRL shift B by A[log2(W)-1:0]; result truncated to W.
- Branch: live = id_valid & !flush & !stall_out. pc_sel = live & (BEQ&A==B | BNE&A!=B | JR). pc_target = JR ? A : id_pc + (id_imm<<2) mod 2^W.
- MDU states IDLE → RUN → IDLE. Ops 10–13 accepted in IDLE when live and !stall_in: operands latched, count=W, HI/LO untouched until done. RUN: one bit per cycle (shift-add / restoring divide on magnitudes), count decrements while !stall_in. At count 0: HI/LO written (MULT: HI=upper, LO=lower; DIV: LO=quotient, HI=remainder), sign fix for signed ops (remainder takes dividend sign), → IDLE.
- Divide by zero: LO = all ones, HI = dividend. Signed MIN/−1: LO=MIN, HI=0.
- stall_out = mdu_busy | (id_valid & op∈{14,15} & RUN). MDU ops themselves retire into EX/MEM as ex_valid=1, ex_regwr=0.
- EX/MEM register: stall_in holds all; else loads live instruction, or bubble (ex_valid=0, ex_regwr=0, ex_ctl=0) when !live. flush never aborts a running MDU op.

## Timing
- Reset: all EX/MEM outputs 0, HI=LO=0, state IDLE, mdu_busy=0, stall_out=0; pc_sel=0 whenever id_valid=0. Reset mid-RUN discards the operation.
- ALU result visible on ex_result one cycle after acceptance.
- MDU accepted at edge N → mdu_busy high N..N+W (W stall-free cycles), HI/LO valid after edge N+W; MFHI in ID at N+1 held until mdu_busy falls, completes next cycle.
- stall_in during RUN extends latency by exactly the stalled cycles.

## Configuration
- EXE_MDU_DIV_EN defined: DIV/DIVU implemented as above. Undefined: divider logic omitted; ops 12/13 retire as no-ops (no stall, HI/LO unchanged); multiply unaffected.

## Test plan
- ADD 5+7 with rs=3 matching mem_rd=3, mem_data=100 → ex_result=107 one cycle later; same match on wb only → wb_data used; rs=0 never forwarded.
- BNE A=4,B=4 → pc_sel=0; BEQ id_pc=0x100, imm=3 → pc_sel=1, pc_target=0x10C; JR A=0x400 → target 0x400.
- MULT −3×5 (W=32) → stall_out 32 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFF1; following MFLO returns 0xFFFFFFF1.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 9/0 → LO=0xFFFFFFFF, HI=9; without EXE_MDU_DIV_EN → no stall, HI/LO unchanged.
- stall_in pulsed 3 cycles during MULTU → completion delayed exactly 3 cycles; EX/MEM outputs frozen.
- rst asserted mid-DIV → immediate mdu_busy=0, HI=LO=0, ex_valid=0.
